// File: rtl/hps_uio_target.sv
// HPS user-IO target: decodes UIO commands, latches joystick/button/status words and serves the config ROM (`HPS_UIO_STATUS_READBACK_EN adds cmd 0x29).
// Latency: writes commit one clock after the final word; config bytes take CONF_LAT+1 clocks with IO_WAIT held high until ready.
module hps_uio_target #(
  parameter int WIDE     = 1,
  parameter int CONF_AW  = 10,
  parameter int CONF_LAT = 1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               IO_UIO,
  input  logic               IO_FPGA,
  input  logic               IO_STROBE,
  output logic               IO_WAIT,
  input  logic [15:0]        IO_DIN,
  output logic [15:0]        IO_DOUT,
  output logic               IO_WIDE,
  output logic [31:0]        joystick_0,
  output logic [31:0]        joystick_1,
  output logic [15:0]        buttons,
  output logic [127:0]       status,
  output logic               status_set,
  output logic [CONF_AW-1:0] conf_addr,
  input  logic [7:0]         conf_data
);
  localparam logic [15:0] CMD_JOY0 = 16'h0001;
  localparam logic [15:0] CMD_JOY1 = 16'h0002;
  localparam logic [15:0] CMD_BTN  = 16'h0004;
  localparam logic [15:0] CMD_CONF = 16'h0014;
  localparam logic [15:0] CMD_STAT = 16'h001E;
  localparam logic [15:0] CMD_RDBK = 16'h0029;
  localparam logic [CONF_AW-1:0] CONF_MAX = '1;
  localparam logic [1:0] LAT_CNT = 2'(CONF_LAT);
`ifdef HPS_UIO_STATUS_READBACK_EN
  localparam bit RDBK_EN = 1'b1;
`else
  localparam bit RDBK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t         state;
  logic           uio_q;
  logic [15:0]    cmd;
  logic [3:0]     cnt;
  logic [127:0]   shadow;
  logic           byte_hi;
  logic [7:0]     byte_lo;
  logic [1:0]     wait_cnt;
  logic           conf_end;

  logic           accept;
  logic           word_done;
  logic [15:0]    word;
  logic [3:0]     plen;
  logic [127:0]   sh_next;
  logic [15:0]    rb_word;

  assign IO_WIDE = (WIDE != 0);
  // A strobe coinciding with IO_UIO falling is dropped: abort has priority.
  assign accept  = IO_STROBE && IO_UIO && !IO_FPGA && !IO_WAIT && (state != S_IDLE);
  assign rb_word = status[{cnt[2:0], 4'b0000} +: 16];

  always_comb begin
    word      = IO_DIN;
    word_done = accept;
    if (WIDE == 0) begin
      word      = {IO_DIN[7:0], byte_lo};
      word_done = accept && byte_hi;
    end
  end

  always_comb begin
    case (cmd)
      CMD_JOY0, CMD_JOY1: plen = 4'd2;
      CMD_BTN:            plen = 4'd1;
      CMD_STAT:           plen = 4'd8;
      default:            plen = 4'd0;
    endcase
  end

  always_comb begin
    sh_next = shadow;
    sh_next[{cnt[2:0], 4'b0000} +: 16] = word;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      uio_q      <= 1'b0;
      cmd        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      byte_hi    <= 1'b0;
      byte_lo    <= '0;
      wait_cnt   <= '0;
      conf_end   <= 1'b0;
      IO_WAIT    <= 1'b0;
      IO_DOUT    <= '0;
      joystick_0 <= '0;
      joystick_1 <= '0;
      buttons    <= '0;
      status     <= '0;
      status_set <= 1'b0;
      conf_addr  <= '0;
    end else begin
      uio_q      <= IO_UIO;
      status_set <= 1'b0;
      if (!IO_UIO) begin
        state   <= S_IDLE;
        IO_WAIT <= 1'b0;
        IO_DOUT <= '0;
        byte_hi <= 1'b0;
      end else begin
        if (accept && WIDE == 0) begin
          byte_hi <= !byte_hi;
          byte_lo <= IO_DIN[7:0];
        end
        case (state)
          S_IDLE: begin
            if (!uio_q) begin
              state   <= S_CMD;
              byte_hi <= 1'b0;
            end
          end
          S_CMD: begin
            if (word_done) begin
              cmd     <= word;
              cnt     <= '0;
              state   <= S_DATA;
              IO_DOUT <= '0;
              if (word == CMD_CONF) begin
                conf_addr <= '0;
                conf_end  <= 1'b0;
                IO_WAIT   <= 1'b1;
                wait_cnt  <= LAT_CNT;
              end
              if (RDBK_EN && word == CMD_RDBK) begin
                IO_DOUT <= status[15:0];
                cnt     <= 4'd1;
              end
            end
          end
          default: begin
            if (cmd == CMD_CONF) begin
              if (IO_WAIT) begin
                if (wait_cnt != 2'd0) begin
                  wait_cnt <= wait_cnt - 2'd1;
                end else begin
                  // The last ROM byte is served once, then zeros.
                  IO_WAIT <= 1'b0;
                  IO_DOUT <= conf_end ? 16'h0000 : {8'h00, conf_data};
                  if (conf_addr == CONF_MAX) conf_end <= 1'b1;
                  else conf_addr <= conf_addr + 1'b1;
                end
              end else if (accept) begin
                IO_WAIT  <= 1'b1;
                wait_cnt <= LAT_CNT;
              end
            end else if (RDBK_EN && cmd == CMD_RDBK) begin
              if (accept) begin
                IO_DOUT <= (cnt < 4'd8) ? rb_word : 16'h0000;
                if (cnt != 4'd8) cnt <= cnt + 4'd1;
              end
            end else if (word_done) begin
              if (cnt < plen) begin
                shadow <= sh_next;
                if (cnt + 4'd1 == plen) begin
                  case (cmd)
                    CMD_JOY0: joystick_0 <= sh_next[31:0];
                    CMD_JOY1: joystick_1 <= sh_next[31:0];
                    CMD_BTN:  buttons    <= sh_next[15:0];
                    CMD_STAT: begin
                      status     <= sh_next;
                      status_set <= 1'b1;
                    end
                    default: ;
                  endcase
                end
              end
              if (cnt != 4'd8) cnt <= cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hps_uio_target.sv
// Directed bench: instance A is 16-bit wide with a 2-clock config ROM, instance B is byte-wide with a 4-byte, 1-clock ROM.
module tb_hps_uio_target;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_uio = 0, a_fpga = 0, a_stb = 0;
  logic [15:0]  a_din = 0;
  logic         a_wait, a_wide, a_sset;
  logic [15:0]  a_dout, a_btn;
  logic [31:0]  a_joy0, a_joy1;
  logic [127:0] a_stat;
  logic [9:0]   a_addr;
  logic [7:0]   a_data = 0, a_s1 = 0;
  logic [7:0]   rom_a [0:1023];

  logic         b_uio = 0, b_fpga = 0, b_stb = 0;
  logic [15:0]  b_din = 0;
  logic         b_wait, b_wide, b_sset;
  logic [15:0]  b_dout, b_btn;
  logic [31:0]  b_joy0, b_joy1;
  logic [127:0] b_stat;
  logic [1:0]   b_addr;
  logic [7:0]   b_data = 0;
  logic [7:0]   rom_b [0:3];

  int n_chk = 0;
  int n_fail = 0;
  int n;

  hps_uio_target #(.WIDE(1), .CONF_AW(10), .CONF_LAT(2)) u_a (
    .clk_sys(clk), .reset_n(reset_n), .IO_UIO(a_uio), .IO_FPGA(a_fpga), .IO_STROBE(a_stb),
    .IO_WAIT(a_wait), .IO_DIN(a_din), .IO_DOUT(a_dout), .IO_WIDE(a_wide),
    .joystick_0(a_joy0), .joystick_1(a_joy1), .buttons(a_btn), .status(a_stat),
    .status_set(a_sset), .conf_addr(a_addr), .conf_data(a_data));

  hps_uio_target #(.WIDE(0), .CONF_AW(2), .CONF_LAT(1)) u_b (
    .clk_sys(clk), .reset_n(reset_n), .IO_UIO(b_uio), .IO_FPGA(b_fpga), .IO_STROBE(b_stb),
    .IO_WAIT(b_wait), .IO_DIN(b_din), .IO_DOUT(b_dout), .IO_WIDE(b_wide),
    .joystick_0(b_joy0), .joystick_1(b_joy1), .buttons(b_btn), .status(b_stat),
    .status_set(b_sset), .conf_addr(b_addr), .conf_data(b_data));

  // ROM models: A has two register stages, B has one.
  always @(posedge clk) begin
    a_s1   <= rom_a[a_addr];
    a_data <= a_s1;
    b_data <= rom_b[b_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe_a(input logic [15:0] d);
    a_din = d;
    a_stb = 1'b1;
    tick();
    a_stb = 1'b0;
  endtask

  task automatic strobe_b(input logic [7:0] d);
    b_din = {8'h00, d};
    b_stb = 1'b1;
    tick();
    b_stb = 1'b0;
  endtask

  task automatic wait_a(output int cyc);
    cyc = 0;
    while (a_wait && cyc < 20) begin
      cyc++;
      tick();
    end
  endtask

  task automatic wait_b(output int cyc);
    cyc = 0;
    while (b_wait && cyc < 20) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_a[i] = 8'h5A;
    rom_a[0] = 8'h41;
    rom_a[1] = 8'h42;
    rom_a[2] = 8'h00;
    rom_b[0] = 8'h11;
    rom_b[1] = 8'h22;
    rom_b[2] = 8'h33;
    rom_b[3] = 8'h44;

    tick(); tick();
    chk("rst_dout", a_dout, 0);
    chk("rst_wait", a_wait, 0);
    chk("rst_joy0", a_joy0, 0);
    chk("rst_stat", a_stat, 0);
    chk("rst_sset", a_sset, 0);
    chk("rst_wide_a", a_wide, 1);
    chk("rst_wide_b", b_wide, 0);
    reset_n = 1'b1;
    tick();

    // Joystick 0 write, back-to-back strobes
    a_uio = 1'b1; tick();
    strobe_a(16'h0001);
    strobe_a(16'hBEEF);
    chk("joy0_shadowed", a_joy0, 0);
    strobe_a(16'h1234);
    chk("joy0_commit", a_joy0, 32'h1234BEEF);
    chk("joy0_dout", a_dout, 0);
    a_uio = 1'b0; tick();

    // Status write with an FPGA-side strobe and an extra word mixed in
    a_uio = 1'b1; tick();
    strobe_a(16'h001E);
    for (int i = 0; i < 7; i++) strobe_a(16'(i));
    a_fpga = 1'b1; strobe_a(16'hDEAD); a_fpga = 1'b0;
    chk("stat_pending", a_stat, 0);
    chk("stat_set_low", a_sset, 0);
    strobe_a(16'h0007);
    chk("stat_commit", a_stat, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("stat_set_pulse", a_sset, 1);
    tick();
    chk("stat_set_single", a_sset, 0);
    strobe_a(16'hFFFF);
    chk("stat_extra_word", a_stat, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("stat_set_extra", a_sset, 0);
    a_uio = 1'b0; tick();

    // Aborted joystick 1, then buttons
    a_uio = 1'b1; tick();
    strobe_a(16'h0002);
    strobe_a(16'hAAAA);
    a_uio = 1'b0; tick();
    chk("joy1_abort", a_joy1, 0);
    a_uio = 1'b1; tick();
    strobe_a(16'h0004);
    strobe_a(16'h0055);
    chk("btn_commit", a_btn, 16'h0055);
    a_uio = 1'b0; tick();

    // UIO fall together with a strobe: strobe must be dropped
    a_uio = 1'b1; tick();
    strobe_a(16'h0004);
    a_din = 16'h0077; a_stb = 1'b1; a_uio = 1'b0;
    tick();
    a_stb = 1'b0;
    chk("abort_race_btn", a_btn, 16'h0055);

    // Config string read, CONF_LAT=2
    a_uio = 1'b1; tick();
    strobe_a(16'h0014);
    chk("conf_addr_start", a_addr, 0);
    wait_a(n);
    chk("conf0_wait_clks", n, 3);
    chk("conf0_dout", a_dout, 16'h0041);
    chk("conf0_addr", a_addr, 1);
    strobe_a(16'h0000);
    wait_a(n);
    chk("conf1_wait_clks", n, 3);
    chk("conf1_dout", a_dout, 16'h0042);
    strobe_a(16'h0000);
    strobe_a(16'h0000);
    wait_a(n);
    chk("conf2_wait_after_ignored", n, 2);
    chk("conf2_dout", a_dout, 16'h0000);
    chk("conf2_addr", a_addr, 3);
    strobe_a(16'h0000);
    wait_a(n);
    chk("conf3_dout", a_dout, 16'h005A);
    tick(); tick(); tick();
    chk("conf3_hold", a_dout, 16'h005A);
    a_uio = 1'b0; tick();
    chk("idle_dout", a_dout, 0);
    a_uio = 1'b1; tick();
    strobe_a(16'h0014);
    chk("fetch_wait_high", a_wait, 1);
    a_uio = 1'b0; tick();
    chk("fetch_abort_wait", a_wait, 0);

    // 0x29: status readback when enabled, otherwise an unknown command
    a_uio = 1'b1; tick();
    strobe_a(16'h0029);
    chk("rdbk_word0", a_dout, 16'h0000);
    strobe_a(16'h0000);
`ifdef HPS_UIO_STATUS_READBACK_EN
    chk("rdbk_word1", a_dout, 16'h0001);
`else
    chk("rdbk_unknown", a_dout, 16'h0000);
`endif
    a_uio = 1'b0; tick();
    a_uio = 1'b1; tick();
    strobe_a(16'h0033);
    strobe_a(16'h9999);
    strobe_a(16'h8888);
    chk("unknown_dout", a_dout, 0);
    chk("unknown_btn", a_btn, 16'h0055);
    chk("unknown_joy0", a_joy0, 32'h1234BEEF);
    a_uio = 1'b0; tick();

    // Byte-wide instance: joystick 0 from bytes, low first
    b_uio = 1'b1; tick();
    strobe_b(8'h01); strobe_b(8'h00);
    strobe_b(8'hEF); strobe_b(8'hBE); strobe_b(8'h34);
    chk("b_joy0_half", b_joy0, 0);
    strobe_b(8'h12);
    chk("b_joy0_commit", b_joy0, 32'h1234BEEF);
    b_uio = 1'b0; tick();

    // Byte-wide config read up to and past the last ROM address
    b_uio = 1'b1; tick();
    strobe_b(8'h14); strobe_b(8'h00);
    wait_b(n);
    chk("b_conf_wait_clks", n, 2);
    chk("b_conf0", b_dout, 16'h0011);
    strobe_b(8'h00); wait_b(n);
    chk("b_conf1", b_dout, 16'h0022);
    strobe_b(8'h00); wait_b(n);
    chk("b_conf2", b_dout, 16'h0033);
    strobe_b(8'h00); wait_b(n);
    chk("b_conf3", b_dout, 16'h0044);
    chk("b_addr_sat", b_addr, 2'd3);
    strobe_b(8'h00); wait_b(n);
    chk("b_conf_past_end", b_dout, 16'h0000);
    chk("b_addr_sat2", b_addr, 2'd3);
    b_uio = 1'b0; tick();

    // Reset in the middle of a status write
    a_uio = 1'b1; tick();
    strobe_a(16'h001E);
    for (int i = 0; i < 4; i++) strobe_a(16'h1111);
    reset_n = 1'b0;
    a_uio = 1'b0;
    #1;
    chk("rst_mid_stat", a_stat, 0);
    chk("rst_mid_joy0", a_joy0, 0);
    chk("rst_mid_btn", a_btn, 0);
    chk("rst_mid_b_joy0", b_joy0, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    a_uio = 1'b1; tick();
    strobe_a(16'h0004);
    strobe_a(16'h0001);
    chk("post_rst_btn", a_btn, 16'h0001);
    chk("post_rst_stat", a_stat, 0);
    a_uio = 1'b0; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
